// File: rtl/trace_reader_pkg.sv
// Shared definitions for the trace buffer reader: display timing, record
// layout, bus ownership states and the next-line wrap helper.
package raybox_trace_pkg;

   localparam int POS_W   = 10;
   localparam int VDIST_W = 16;
   localparam int WTID_W  = 2;
   localparam int TEX_W   = 6;

   localparam logic [POS_W-1:0] H_VIEW  = 10'd640;
   localparam logic [POS_W-1:0] H_TOTAL = 10'd800;
   localparam logic [POS_W-1:0] V_VIEW  = 10'd480;
   localparam logic [POS_W-1:0] V_TOTAL = 10'd525;

   // Clocks between issuing a column address and the record appearing on col_*.
   localparam logic [POS_W:0]   FETCH_LEAD = 11'd3;

   // One trace record as stored per column in the trace buffer.
   typedef struct packed {
      logic [VDIST_W-1:0] vdist;
      logic [WTID_W-1:0]  wtid;
      logic               side;
      logic [TEX_W-1:0]   tex;
   } trace_rec_t;

   // Bus ownership: the reader prefetches in READ, the tracer writes in GRANT.
   typedef enum logic {
      READ  = 1'b0,
      GRANT = 1'b1
   } bus_state_e;

   // Line that follows v, wrapping the last line of the frame back to 0.
   function automatic logic [POS_W-1:0] wrap_line(input logic [POS_W-1:0] v);
      logic [POS_W-1:0] nxt;
      if (v == (V_TOTAL - 10'd1)) begin
         nxt = 10'd0;
      end else begin
         nxt = v + 10'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/trace_bus_arbiter.sv
// Trace buffer bus arbiter. The tracer may own the bus only during vblank
// (lines V_VIEW..V_TOTAL-2); ownership is forcibly revoked on the last line
// so the reader can prefetch the first columns of the next frame.
module trace_bus_arbiter
   import raybox_trace_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             tracer_req,
   input  logic [POS_W-1:0] vpos,
   output logic             tracer_gnt,
   output logic             read_en
);

   bus_state_e state_q;
   bus_state_e state_d;
   logic       gnt_q;
   logic       revoke_s;
   logic       grant_window_s;

   assign revoke_s       = (vpos == (V_TOTAL - 10'd1));
   assign grant_window_s = (vpos >= V_VIEW) && (vpos < (V_TOTAL - 10'd1));

   // Next bus owner; a pending revoke overrides any tracer request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         READ: begin
            if (tracer_req && grant_window_s) begin
               state_d = GRANT;
            end else begin
               state_d = READ;
            end
         end
         GRANT: begin
            if (revoke_s || !tracer_req) begin
               state_d = READ;
            end else begin
               state_d = GRANT;
            end
         end
         default: begin
            state_d = READ;
         end
      endcase
   end

   // State register and registered grant; reset returns the bus to the reader.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= READ;
         gnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= (state_d == GRANT);
      end
   end

   assign tracer_gnt = gnt_q;
   assign read_en    = (state_q == READ);

endmodule

// File: rtl/trace_reader.sv
// Read-side client of the trace buffer. Prefetches the trace record for the
// column FETCH_LEAD clocks ahead of hpos so col_* line up with the current
// pixel, and yields the bus to the tracer during vblank.
// Optional build macro: TRACE_READER_HALF_RES_EN (one trace per 2 pixels).
module trace_reader
   import raybox_trace_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [POS_W-1:0]   hpos,
   input  logic [POS_W-1:0]   vpos,
   output logic               tb_cs,
   output logic               tb_oe,
   output logic               tb_we,
   output logic [POS_W-1:0]   tb_column,
   input  logic [VDIST_W-1:0] tb_vdist,
   input  logic [WTID_W-1:0]  tb_wtid,
   input  logic               tb_side,
   input  logic [TEX_W-1:0]   tb_tex,
   input  logic               tracer_req,
   output logic               tracer_gnt,
   output logic               col_valid,
   output logic [VDIST_W-1:0] col_vdist,
   output logic [WTID_W-1:0]  col_wtid,
   output logic               col_side,
   output logic [TEX_W-1:0]   col_tex
);

   logic [POS_W:0]   hsum_s;
   logic [POS_W-1:0] fh_s;
   logic [POS_W-1:0] fl_s;
   logic             read_en_s;
   logic             fetch_en_s;

   logic             tb_cs_q;
   logic             tb_cs_d;
   logic [POS_W-1:0] tb_column_q;
   logic [POS_W-1:0] tb_column_d;
   logic             bus_valid_q;
   logic             bus_valid_d;
   logic             col_valid_q;
   logic             col_valid_d;
   trace_rec_t       col_rec_q;
   trace_rec_t       col_rec_d;
   trace_rec_t       bus_rec_s;

   trace_bus_arbiter u_arbiter (
      .clk        (clk),
      .reset      (reset),
      .tracer_req (tracer_req),
      .vpos       (vpos),
      .tracer_gnt (tracer_gnt),
      .read_en    (read_en_s)
   );

   assign bus_rec_s = '{vdist: tb_vdist, wtid: tb_wtid, side: tb_side, tex: tb_tex};

   // Column/line being prefetched; wraps by compare-and-subtract so the
   // three clocks past the end of a line land on the next line's start.
   always_comb begin
      hsum_s = {1'b0, hpos} + FETCH_LEAD;
      if (hsum_s >= {1'b0, H_TOTAL}) begin
         fh_s = hsum_s[POS_W-1:0] - H_TOTAL;
         fl_s = wrap_line(vpos);
      end else begin
         fh_s = hsum_s[POS_W-1:0];
         fl_s = vpos;
      end
      fetch_en_s = (fh_s < H_VIEW) && (fl_s < V_VIEW) && read_en_s;
   end

   // Next values of the address stage and the valid/data pipeline.
   always_comb begin
      tb_cs_d     = fetch_en_s;
      tb_column_d = tb_column_q;
      if (fetch_en_s) begin
`ifdef TRACE_READER_HALF_RES_EN
         // Even pixels start a new trace; odd pixels keep cs/oe and the
         // address so the buffer keeps presenting the same record. A run
         // that starts on an odd pixel has nothing held yet, so it loads too.
         if (!fh_s[0] || !tb_cs_q) begin
            tb_column_d = {1'b0, fh_s[POS_W-1:1]};
         end else begin
            tb_column_d = tb_column_q;
         end
`else
         tb_column_d = fh_s;
`endif
      end else begin
         tb_column_d = tb_column_q;
      end
      bus_valid_d = tb_cs_q;
      col_valid_d = bus_valid_q;
      if (bus_valid_q) begin
         col_rec_d = bus_rec_s;
      end else begin
         col_rec_d = '0;
      end
   end

   // Pipeline registers; reset clears every output in the following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         tb_cs_q     <= 1'b0;
         tb_column_q <= 10'd0;
         bus_valid_q <= 1'b0;
         col_valid_q <= 1'b0;
         col_rec_q   <= '0;
      end else begin
         tb_cs_q     <= tb_cs_d;
         tb_column_q <= tb_column_d;
         bus_valid_q <= bus_valid_d;
         col_valid_q <= col_valid_d;
         col_rec_q   <= col_rec_d;
      end
   end

   assign tb_cs     = tb_cs_q;
   assign tb_oe     = tb_cs_q;
   assign tb_we     = 1'b0;
   assign tb_column = tb_column_q;
   assign col_valid = col_valid_q;
   assign col_vdist = col_rec_q.vdist;
   assign col_wtid  = col_rec_q.wtid;
   assign col_side  = col_rec_q.side;
   assign col_tex   = col_rec_q.tex;

endmodule

// File: tb/tb_trace_reader.sv
// Scoreboard bench for trace_reader: a buffer model answers reads, the
// stimulus process predicts each cycle's outputs from the display rules and
// pushes them into a queue, and a monitor pops and compares every cycle.
module tb_trace_reader;

`ifdef TRACE_READER_HALF_RES_EN
   localparam bit HALF = 1'b1;
   localparam int NREC = 320;
`else
   localparam bit HALF = 1'b0;
   localparam int NREC = 640;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hpos, vpos;
   logic        tb_cs, tb_oe, tb_we;
   logic [9:0]  tb_column;
   logic [15:0] tb_vdist;
   logic [1:0]  tb_wtid;
   logic        tb_side;
   logic [5:0]  tb_tex;
   logic        tracer_req, tracer_gnt;
   logic        col_valid;
   logic [15:0] col_vdist;
   logic [1:0]  col_wtid;
   logic        col_side;
   logic [5:0]  col_tex;

   always #5 clk = ~clk;

   trace_reader dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
      .tb_cs(tb_cs), .tb_oe(tb_oe), .tb_we(tb_we), .tb_column(tb_column),
      .tb_vdist(tb_vdist), .tb_wtid(tb_wtid), .tb_side(tb_side), .tb_tex(tb_tex),
      .tracer_req(tracer_req), .tracer_gnt(tracer_gnt),
      .col_valid(col_valid), .col_vdist(col_vdist), .col_wtid(col_wtid),
      .col_side(col_side), .col_tex(col_tex)
   );

   // Trace buffer contents and its registered read port.
   logic [15:0] mem_vdist [0:639];
   logic [1:0]  mem_wtid  [0:639];
   logic        mem_side  [0:639];
   logic [5:0]  mem_tex   [0:639];

   always @(posedge clk) begin
      if (tb_cs && tb_oe && !tb_we) begin
         tb_vdist <= mem_vdist[tb_column];
         tb_wtid  <= mem_wtid[tb_column];
         tb_side  <= mem_side[tb_column];
         tb_tex   <= mem_tex[tb_column];
      end
   end

   typedef struct {
      logic        cs;
      logic [9:0]  column;
      logic        gnt;
      logic        valid;
      logic [15:0] vdist;
      logic [1:0]  wtid;
      logic        side;
      logic [5:0]  tex;
      int          h;
      int          v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state: inputs of the previous cycle, expected current
   // address/grant, and the last three fetch issues with reset history.
   int  p_h = 0, p_v = 0;
   bit  p_req = 1'b0, p_rst = 1'b1;
   bit  m_gnt = 1'b0, m_cs = 1'b0;
   int  m_col = 0;
   bit  iss [3] = '{1'b0, 1'b0, 1'b0};
   int  ifh [3] = '{0, 0, 0};
   bit  rsth[3] = '{1'b1, 1'b1, 1'b1};
   bit  rreq = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                      input int h, input int v);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at vpos=%0d hpos=%0d: got %0h expected %0h", nm, v, h, act, exp);
      end
   endtask

   // One clock: predict this cycle's outputs from earlier inputs, then
   // drive this cycle's inputs.
   task automatic step(input int h, input int v, input bit req, input bit rst);
      int   fh, fl, idx;
      bit   en, ngnt;
      exp_t e;
      @(posedge clk);
      #1;
      fh = (p_h + 3) % 800;
      fl = (p_h + 3 >= 800) ? (p_v + 1) % 525 : p_v;
      en = !p_rst && (fh < 640) && (fl < 480) && !m_gnt;
      if (p_rst)      ngnt = 1'b0;
      else if (m_gnt) ngnt = p_req && (p_v != 524);
      else            ngnt = p_req && (p_v >= 480) && (p_v < 524);
      m_cs  = en;
      if (p_rst)   m_col = 0;
      else if (en) m_col = HALF ? fh / 2 : fh;
      m_gnt = ngnt;
      iss[2] = iss[1];   iss[1] = iss[0];   iss[0] = en;
      ifh[2] = ifh[1];   ifh[1] = ifh[0];   ifh[0] = fh;
      rsth[2] = rsth[1]; rsth[1] = rsth[0]; rsth[0] = p_rst;
      e.cs     = m_cs;
      e.column = m_col[9:0];
      e.gnt    = m_gnt;
      e.valid  = iss[2] && !rsth[1] && !rsth[0];
      idx      = HALF ? ifh[2] / 2 : ifh[2];
      e.vdist  = e.valid ? mem_vdist[idx] : 16'd0;
      e.wtid   = e.valid ? mem_wtid[idx]  : 2'd0;
      e.side   = e.valid ? mem_side[idx]  : 1'b0;
      e.tex    = e.valid ? mem_tex[idx]   : 6'd0;
      e.h      = h;
      e.v      = v;
      sb.push_back(e);
      hpos       = h[9:0];
      vpos       = v[9:0];
      tracer_req = req;
      reset      = rst;
      p_h = h; p_v = v; p_req = req; p_rst = rst;
   endtask

   // Run n clocks of raster timing from (v0,h0).
   // mode 0: req low, 1: req high, 2: random req, 3: random req and resets.
   task automatic run(input int v0, input int h0, input int n, input int mode);
      int h = h0;
      int v = v0;
      bit req, rst;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 15) == 0) rreq = ~rreq;
         req = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : rreq;
         rst = (mode == 3) && ($urandom_range(0, 199) == 0);
         step(h, v, req, rst);
         h++;
         if (h == 800) begin
            h = 0;
            v = (v == 524) ? 0 : v + 1;
         end
      end
   endtask

   // Monitor: compare the DUT against the oldest prediction mid-cycle.
   exp_t me;
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         me = sb.pop_front();
         chk("tb_cs",      {31'd0, tb_cs},      {31'd0, me.cs},     me.h, me.v);
         chk("tb_oe",      {31'd0, tb_oe},      {31'd0, me.cs},     me.h, me.v);
         chk("tb_we",      {31'd0, tb_we},      32'd0,              me.h, me.v);
         chk("tb_column",  {22'd0, tb_column},  {22'd0, me.column}, me.h, me.v);
         chk("tracer_gnt", {31'd0, tracer_gnt}, {31'd0, me.gnt},    me.h, me.v);
         chk("col_valid",  {31'd0, col_valid},  {31'd0, me.valid},  me.h, me.v);
         chk("col_vdist",  {16'd0, col_vdist},  {16'd0, me.vdist},  me.h, me.v);
         chk("col_wtid",   {30'd0, col_wtid},   {30'd0, me.wtid},   me.h, me.v);
         chk("col_side",   {31'd0, col_side},   {31'd0, me.side},   me.h, me.v);
         chk("col_tex",    {26'd0, col_tex},    {26'd0, me.tex},    me.h, me.v);
         if (me.v == 10 && me.valid) begin
            if (!HALF && me.h == 100) begin
               chk("pix100_vdist", {16'd0, col_vdist}, 32'd300, me.h, me.v);
               chk("pix100_tex",   {26'd0, col_tex},   32'd36,  me.h, me.v);
            end
            if (HALF && (me.h == 100 || me.h == 101)) begin
               chk("half_vdist", {16'd0, col_vdist}, 32'd50, me.h, me.v);
            end
         end
      end
   end

   initial begin
      int h0;
      for (int c = 0; c < NREC; c++) begin
         mem_vdist[c] = HALF ? 16'(c) : 16'(c * 3);
         mem_tex[c]   = 6'(c % 64);
         mem_wtid[c]  = 2'($urandom_range(0, 3));
         mem_side[c]  = 1'($urandom_range(0, 1));
      end
      reset = 1'b1; tracer_req = 1'b0; hpos = 10'd87; vpos = 10'd10;
      for (int i = 0; i < 3; i++) step(87 + i, 10, 1'b0, 1'b1);
      // Visible line with column 639 and the 640 boundary.
      run(10, 90, 650, 2);
      // Request during active video is not granted.
      run(5, 0, 100, 1);
      // Last line of the frame into line 0 prefetch.
      run(523, 700, 1000, 2);
      // Grant from line 480, release at 490, then forced revoke on 524.
      run(479, 790, 8010, 1);
      run(490, 0, 1600, 0);
      run(522, 0, 2450, 1);
      // Obtain the grant, jump into active video, reset at the edge into hpos 300.
      run(485, 0, 20, 1);
      run(20, 290, 9, 1);
      step(299, 20, 1'b1, 1'b1);
      run(20, 300, 400, 1);
      // Randomised positions, requests and resets.
      for (int s = 0; s < 20; s++) begin
         h0 = $urandom_range(0, 799);
         if (HALF) h0 = h0 | 1;
         if (h0 > 799) h0 = 799;
         run($urandom_range(0, 524), h0, 300, 3);
      end
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
